// File: rtl/ibex_vector_elem_seq.sv
`default_nettype none
// ============================================================================
// Module : ibex_vector_elem_seq
// Desc   : Splits one vector command into per-VLEN-word micro-op beats with
//          tail byte masking.
// Rev    : 1.0
// ============================================================================
module ibex_vector_elem_seq #(
  parameter int VLENB = 4,
  parameter int NREG  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [4:0]           vl_i,
  input  logic [2:0]           vsew_i,
  input  logic [2:0]           vlmul_i,
  input  logic [$clog2(NREG)-1:0] vd_i,
  input  logic [$clog2(NREG)-1:0] vs1_i,
  input  logic [$clog2(NREG)-1:0] vs2_i,
  output logic                 uop_valid_o,
  input  logic                 uop_ready_i,
  output logic [$clog2(NREG)-1:0] uop_vd_o,
  output logic [$clog2(NREG)-1:0] uop_vs1_o,
  output logic [$clog2(NREG)-1:0] uop_vs2_o,
  output logic [VLENB-1:0]     uop_be_o,
  output logic [4:0]           uop_elem_o,
  output logic                 uop_first_o,
  output logic                 uop_last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int C_RW = $clog2(NREG);
  localparam int C_BW = $clog2(VLENB);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t           r_state;
  logic [2:0]       r_beat;
  logic [2:0]       r_nbeats;
  logic [4:0]       r_epw;
  logic [VLENB-1:0] r_tailmask;
  logic             r_cmd_ready, r_busy, r_done, r_err;
  logic             r_uop_valid, r_uop_first, r_uop_last;
  logic [C_RW-1:0]  r_uop_vd, r_uop_vs1, r_uop_vs2;
  logic [VLENB-1:0] r_uop_be;
  logic [4:0]       r_uop_elem;

  logic [6:0]       w_bytes;
  logic [2:0]       w_nbeats;
  logic [C_BW-1:0]  w_tail;
  logic [VLENB-1:0] w_tailmask;
  logic [4:0]       w_epw;
  logic [4:0]       w_vlmax;
  logic [C_RW-1:0]  w_mask;
  logic             w_illegal;
  logic [2:0]       w_next_beat;
  logic             w_next_last;

  // Illegal vsew values produce garbage here but are rejected by w_illegal.
  assign w_bytes    = {2'b00, vl_i} << vsew_i[1:0];
  assign w_nbeats   = 3'((w_bytes + 7'(VLENB - 1)) >> C_BW);
  assign w_tail     = w_bytes[C_BW-1:0];
  assign w_tailmask = (w_tail == '0) ? '1 : VLENB'((1 << w_tail) - 1);
  assign w_epw      = 5'(VLENB >> vsew_i[1:0]);
  assign w_vlmax    = w_epw << vlmul_i[1:0];
  assign w_mask     = C_RW'((1 << vlmul_i[1:0]) - 1);
  assign w_illegal  = (vsew_i > 3'd2) || (vlmul_i > 3'd2) || (vl_i > w_vlmax) ||
                      ((vd_i & w_mask) != '0) || ((vs1_i & w_mask) != '0) ||
                      ((vs2_i & w_mask) != '0);

  assign w_next_beat = r_beat + 3'd1;
  assign w_next_last = (w_next_beat == r_nbeats - 3'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_nbeats    <= '0;
      r_epw       <= '0;
      r_tailmask  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_uop_valid <= 1'b0;
      r_uop_first <= 1'b0;
      r_uop_last  <= 1'b0;
      r_uop_vd    <= '0;
      r_uop_vs1   <= '0;
      r_uop_vs2   <= '0;
      r_uop_be    <= '0;
      r_uop_elem  <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else if (vl_i == 5'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state     <= S_ISSUE;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_beat      <= '0;
              r_nbeats    <= w_nbeats;
              r_epw       <= w_epw;
              r_tailmask  <= w_tailmask;
              r_uop_valid <= 1'b1;
              r_uop_first <= 1'b1;
              r_uop_last  <= (w_nbeats == 3'd1);
              r_uop_vd    <= vd_i;
              r_uop_vs1   <= vs1_i;
              r_uop_vs2   <= vs2_i;
              r_uop_be    <= (w_nbeats == 3'd1) ? w_tailmask : '1;
              r_uop_elem  <= '0;
            end
          end
        end
        S_ISSUE: begin
          // Fields only move on a handshake, so they hold under backpressure.
          if (uop_ready_i) begin
            if (r_uop_last) begin
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_uop_valid <= 1'b0;
              r_uop_first <= 1'b0;
              r_uop_last  <= 1'b0;
              r_uop_vd    <= '0;
              r_uop_vs1   <= '0;
              r_uop_vs2   <= '0;
              r_uop_be    <= '0;
              r_uop_elem  <= '0;
            end else begin
              r_beat      <= w_next_beat;
              r_uop_first <= 1'b0;
              r_uop_last  <= w_next_last;
              r_uop_vd    <= r_uop_vd + 1'b1;
              r_uop_vs1   <= r_uop_vs1 + 1'b1;
              r_uop_vs2   <= r_uop_vs2 + 1'b1;
              r_uop_be    <= w_next_last ? r_tailmask : '1;
              r_uop_elem  <= r_uop_elem + r_epw;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign uop_valid_o = r_uop_valid;
  assign uop_first_o = r_uop_first;
  assign uop_last_o  = r_uop_last;
  assign uop_vd_o    = r_uop_vd;
  assign uop_vs1_o   = r_uop_vs1;
  assign uop_vs2_o   = r_uop_vs2;
  assign uop_be_o    = r_uop_be;
  assign uop_elem_o  = r_uop_elem;

endmodule
`default_nettype wire

// File: tb/tb_ibex_vector_elem_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_ibex_vector_elem_seq
// Desc   : Directed scoreboard bench for the vector element sequencer.
// Rev    : 1.0
// ============================================================================
module tb_ibex_vector_elem_seq;

  logic       clk_i = 1'b0;
  logic       rst_i, cmd_valid_i, cmd_ready_o, uop_ready_i;
  logic [4:0] vl_i, vd_i, vs1_i, vs2_i;
  logic [2:0] vsew_i, vlmul_i;
  logic       uop_valid_o, uop_first_o, uop_last_o, busy_o, done_o, err_o;
  logic [4:0] uop_vd_o, uop_vs1_o, uop_vs2_o, uop_elem_o;
  logic [3:0] uop_be_o;

  typedef struct packed {
    logic [4:0] vd, vs1, vs2;
    logic [3:0] be;
    logic [4:0] elem;
    logic       first, last;
  } beat_t;

  beat_t sb[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  always #5 clk_i = ~clk_i;

  ibex_vector_elem_seq #(.VLENB(4), .NREG(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .vl_i(vl_i), .vsew_i(vsew_i), .vlmul_i(vlmul_i), .vd_i(vd_i), .vs1_i(vs1_i),
    .vs2_i(vs2_i), .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i),
    .uop_vd_o(uop_vd_o), .uop_vs1_o(uop_vs1_o), .uop_vs2_o(uop_vs2_o),
    .uop_be_o(uop_be_o), .uop_elem_o(uop_elem_o), .uop_first_o(uop_first_o),
    .uop_last_o(uop_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b = '{vd: uop_vd_o, vs1: uop_vs1_o, vs2: uop_vs2_o, be: uop_be_o,
          elem: uop_elem_o, first: uop_first_o, last: uop_last_o};
    return b;
  endfunction

  // Reference model: push the beats a legal command should produce.
  task automatic push_expected(input int vl, input int vsew, input int vlmul,
                               input int vd, input int vs1, input int vs2);
    int    bytes, nb, tail;
    beat_t b;
    bytes = vl * (1 << vsew);
    nb    = (bytes + 3) / 4;
    tail  = bytes % 4;
    for (int i = 0; i < nb; i++) begin
      b.vd    = 5'((vd + i) % 32);
      b.vs1   = 5'((vs1 + i) % 32);
      b.vs2   = 5'((vs2 + i) % 32);
      b.elem  = 5'(i * (4 >> vsew));
      b.first = (i == 0);
      b.last  = (i == nb - 1);
      b.be    = (i == nb - 1 && tail == 1) ? 4'b0001 :
                (i == nb - 1 && tail == 2) ? 4'b0011 :
                (i == nb - 1 && tail == 3) ? 4'b0111 : 4'b1111;
      sb.push_back(b);
    end
  endtask

  task automatic send_cmd(input int vl, input int vsew, input int vlmul,
                          input int vd, input int vs1, input int vs2);
    chk("cmd_ready_before_send", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    vl_i = 5'(vl); vsew_i = 3'(vsew); vlmul_i = 3'(vlmul);
    vd_i = 5'(vd); vs1_i = 5'(vs1); vs2_i = 5'(vs2);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    vl_i = 5'd31; vsew_i = 3'd7; vlmul_i = 3'd7;
  endtask

  // Pops and checks each expected beat, assuming uop_ready_i is high.
  task automatic drain();
    int waitc;
    while (sb.size() > 0) begin
      waitc = 0;
      while (!uop_valid_o && waitc < 20) begin
        @(negedge clk_i);
        waitc++;
      end
      if (!uop_valid_o) begin
        chk("beat_timeout", 32'd0, 32'd1);
        sb.delete();
        return;
      end
      chk("beat", 32'(cur_beat()), 32'(sb.pop_front()));
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; uop_ready_i = 1'b0;
    vl_i = '0; vsew_i = '0; vlmul_i = '0; vd_i = '0; vs1_i = '0; vs2_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_outputs", {26'd0, uop_valid_o, busy_o, done_o, err_o, uop_first_o, uop_last_o}, 32'd0);
    chk("rst_fields", 32'(cur_beat()), 32'd0);

    // e8 m4 vl=13: four beats with a one-byte tail
    uop_ready_i = 1'b1;
    send_cmd(13, 0, 2, 8, 4, 12);
    push_expected(13, 0, 2, 8, 4, 12);
    drain();
    chk("t1_done", {30'd0, done_o, uop_valid_o}, 32'b10);

    // e32 m2 vl=2 with three cycles of backpressure on beat 0
    uop_ready_i = 1'b0;
    send_cmd(2, 2, 1, 2, 0, 0);
    push_expected(2, 2, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", {31'd0, uop_valid_o}, 32'd1);
      chk("t2_hold_beat", 32'(cur_beat()), 32'(sb[0]));
      @(negedge clk_i);
    end
    uop_ready_i = 1'b1;
    drain();
    chk("t2_done", {31'd0, done_o}, 32'd1);

    // illegal: vl above VLMAX
    send_cmd(3, 1, 0, 0, 0, 0);
    chk("t3_err", {28'd0, err_o, done_o, uop_valid_o, cmd_ready_o}, 32'b1001);
    @(negedge clk_i);
    chk("t3_err_pulse", {30'd0, err_o, uop_valid_o}, 32'd0);

    // illegal: misaligned group, vsew=3, vlmul=3
    send_cmd(5, 0, 1, 3, 0, 0);
    chk("t4_misalign", {29'd0, err_o, done_o, uop_valid_o}, 32'b100);
    send_cmd(1, 3, 0, 0, 0, 0);
    chk("t4_vsew3", {29'd0, err_o, done_o, uop_valid_o}, 32'b100);
    send_cmd(1, 0, 3, 0, 0, 0);
    chk("t4_vlmul3", {29'd0, err_o, done_o, uop_valid_o}, 32'b100);

    // vl=0 completes immediately; next command accepted in the done cycle
    send_cmd(0, 0, 0, 0, 0, 0);
    chk("t5_done", {28'd0, done_o, err_o, uop_valid_o, cmd_ready_o}, 32'b1001);
    send_cmd(1, 2, 0, 9, 10, 11);
    push_expected(1, 2, 0, 9, 10, 11);
    chk("t5_b2b_valid", {31'd0, uop_valid_o}, 32'd1);
    drain();
    chk("t5_b2b_done", {31'd0, done_o}, 32'd1);

    // reset during beat 1 of a four-beat command
    send_cmd(4, 2, 2, 4, 8, 12);
    push_expected(4, 2, 2, 4, 8, 12);
    chk("t6_beat0", 32'(cur_beat()), 32'(sb.pop_front()));
    @(negedge clk_i);
    chk("t6_beat1", 32'(cur_beat()), 32'(sb.pop_front()));
    sb.delete();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("t6_after_rst", {28'd0, uop_valid_o, done_o, busy_o, cmd_ready_o}, 32'b0001);
    @(negedge clk_i);
    chk("t6_no_done", {30'd0, done_o, err_o}, 32'd0);
    send_cmd(7, 0, 1, 2, 6, 10);
    push_expected(7, 0, 1, 2, 6, 10);
    drain();
    chk("t6_done", {31'd0, done_o}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ibex_vector_elem_seq.md
Name: ibex_vector_elem_seq

Overview:
- Consumer side of the vector CSR. Accepts one vector-op command carrying the current vl/vsew/vlmul CSR values and base register indices.
- Walks the register group and issues one 32-bit micro-op beat per VLEN word actually covered by vl. Each beat carries the physical register indices and a byte-enable for tail masking.
- Sits between vector decode and the packed-SIMD vector ALU/LSU.

Parameters:
- VLENB, 4, vector register length in bytes (fixed 32-bit VLEN; other values unsupported).
- NREG, 32, number of vector registers; register index width 5.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  sequencer can accept a command
- vl_i  input  5  vl CSR value
- vsew_i  input  3  vtype.vsew (0=8b, 1=16b, 2=32b)
- vlmul_i  input  3  vtype.vlmul (0=x1, 1=x2, 2=x4)
- vd_i  input  5  destination group base
- vs1_i  input  5  source-1 group base
- vs2_i  input  5  source-2 group base
- uop_valid_o  output  1  beat valid
- uop_ready_i  input  1  beat accepted
- uop_vd_o  output  5  vd base + beat index
- uop_vs1_o  output  5  vs1 base + beat index
- uop_vs2_o  output  5  vs2 base + beat index
- uop_be_o  output  4  active byte lanes of the beat
- uop_elem_o  output  5  index of first element in the beat
- uop_first_o  output  1  first beat of command
- uop_last_o  output  1  last beat of command
- busy_o  output  1  state != IDLE
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  one-cycle illegal-config pulse

Behaviour:
- Reset (rst_i sampled high at posedge): state=IDLE. All outputs 0 except cmd_ready_o=1. Reset mid-ISSUE aborts the command with no done_o or err_o.
- Derived values at command accept:
  - esz = 1<<vsew
  - epw = 4>>vsew (elements per word)
  - VLMAX = epw<<vlmul
  - nbeats = ceil(vl*esz/4)
  - tailbytes = (vl*esz) mod 4
- Illegal command if any of:
  - vsew>2 or vlmul>2
  - vl>VLMAX
  - any of vd/vs1/vs2 has nonzero low vlmul bits (group misaligned)
- States: IDLE, ISSUE.
- IDLE: cmd_ready_o=1. On cmd_valid_i & cmd_ready_o:
  - Illegal: err_o=1 next cycle; stay IDLE; no beats.
  - vl==0: done_o=1 next cycle; stay IDLE; no beats.
  - Otherwise: latch operands, beat=0, go to ISSUE.
- ISSUE: cmd_ready_o=0, uop_valid_o=1.
  - Register fields per beat: uop_vd_o = vd+beat (mod 32); same rule for vs1 and vs2.
  - uop_elem_o = beat*epw.
  - uop_first_o = (beat==0); uop_last_o = (beat==nbeats-1).
  - uop_be_o = 4'b1111, except on the last beat when tailbytes!=0, where it is the low tailbytes bits set (1->0001, 2->0011, 3->0111).
  - On uop_ready_i: beat++. If last, go to IDLE and pulse done_o in the following cycle.
- Backpressure: while uop_valid_o & !uop_ready_i, every uop_* output holds stable. uop_valid_o never drops without a handshake.
- First beat is valid the cycle after command accept (1-cycle latency). Throughput is 1 beat/cycle under continuous ready.
- The done_o cycle is IDLE; a new command may be accepted in that same cycle.
- done_o and err_o are registered, single-cycle, and mutually exclusive.
- CSR inputs are sampled only at accept. Changes during ISSUE are ignored.

Test Plan:
- vsew=0, vlmul=2, vl=13, vd=8, vs1=4, vs2=12, ready=1 -> 4 beats: vd 8,9,10,11; vs1 4..7; vs2 12..15; elem 0,4,8,12; be 1111,1111,1111,0001; first on beat0, last on beat3; done_o the cycle after beat3.
- vsew=2, vlmul=1, vl=2, vd=2; uop_ready_i low for 3 cycles on beat0 -> beat0 (vd=2, be=1111) held stable 3 cycles; then beat1 (vd=3, be=1111, last); done_o pulse.
- vsew=1, vlmul=0, vl=3 (VLMAX=2) -> err_o one cycle later; no uop_valid_o; cmd_ready_o stays 1.
- vsew=0, vlmul=1, vd=3 (misaligned), vl=5 -> err_o. Then vsew=3 -> err_o. Then vlmul=3 -> err_o.
- vl=0, legal vtype -> done_o next cycle, zero beats. Back-to-back command accepted in the done_o cycle starts issuing the cycle after.
- rst_i asserted during beat1 of a 4-beat command -> next cycle IDLE, uop_valid_o=0, no done_o; a fresh command issues correctly from beat0.
